halut_decoder_int: RTL and testbench

Integer-accumulation decoder unit for the HALUT matrix-multiply datapath, sitting directly downstream of the encoder. For one output column it consumes the encoder's per-codebook prototype indices (one 4-bit index per codebook, C per input row). It looks each index up in a locally held LUT slice of C×K signed entries and accumulates the C looked-up values exactly. It presents one sum per input row on a valid/ready output toward the result collection logic. Several instances (DecoderUnits) run in parallel, one per output column slice.

---
 rtl/halut_pkg.sv | 19 +
 rtl/halut_decoder_int_lut.sv | 30 +++
 rtl/halut_decoder_int.sv | 106 ++++++++++
 tb/tb_halut_decoder_int.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/halut_pkg.sv
// Shared parameters and index types for the HALUT datapath.
package halut_pkg;

   localparam int C = 32;
   localparam int K = 16;
   localparam int DataTypeWidth = 16;
   localparam int AccWidthInt = DataTypeWidth + $clog2(C);

   typedef logic [$clog2(K)-1:0] k_idx_t;
   typedef logic [$clog2(C)-1:0] c_idx_t;

   typedef enum logic {
      INT,
      FP32
   } acc_opt_e;

   localparam acc_opt_e AccumulationOption = INT;

endpackage

// File: rtl/halut_decoder_int_lut.sv
// C x K signed LUT slice: one synchronous write port, one combinational read.
module halut_lut_regfile
   import halut_pkg::*;
#(
   parameter int C             = halut_pkg::C,
   parameter int K             = halut_pkg::K,
   parameter int DataTypeWidth = halut_pkg::DataTypeWidth
) (
   input  logic                       clk_i,
   input  logic                       we_i,
   input  logic [$clog2(C)-1:0]       wc_i,
   input  logic [$clog2(K)-1:0]       wk_i,
   input  logic [DataTypeWidth-1:0]   wdata_i,
   input  logic [$clog2(C)-1:0]       rc_i,
   input  logic [$clog2(K)-1:0]       rk_i,
   output logic [DataTypeWidth-1:0]   rdata_o
);

   logic [DataTypeWidth-1:0] mem_q [C][K];

   // No reset: contents are owned by the controller.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[wc_i][wk_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rc_i][rk_i];

endmodule

// File: rtl/halut_decoder_int.sv
// HALUT integer decoder: LUT lookup per codebook index, exact row sum.
module halut_decoder_int
   import halut_pkg::*;
#(
   parameter int C             = halut_pkg::C,
   parameter int K             = halut_pkg::K,
   parameter int DataTypeWidth = halut_pkg::DataTypeWidth,
   localparam int AccW         = DataTypeWidth + $clog2(C)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     lut_we_i,
   input  logic [$clog2(C)-1:0]     lut_wc_i,
   input  logic [$clog2(K)-1:0]     lut_wk_i,
   input  logic [DataTypeWidth-1:0] lut_wdata_i,
   input  logic                     enc_valid_i,
   output logic                     enc_ready_o,
   input  logic [$clog2(K)-1:0]     enc_k_i,
   output logic                     result_valid_o,
   input  logic                     result_ready_i,
   output logic [AccW-1:0]          result_o,
   output logic [15:0]              row_o
);

   localparam int CW = $clog2(C);
   localparam logic [CW-1:0] CLast = CW'(C - 1);

   logic [CW-1:0]            c_q, c_d;
   logic [AccW-1:0]          acc_q, acc_d;
   logic [AccW-1:0]          res_q, res_d;
   logic                     vld_q, vld_d;
   logic [15:0]              row_q, row_d;
   logic [15:0]              rcnt_q, rcnt_d;
   logic [DataTypeWidth-1:0] entry;
   logic [AccW-1:0]          entry_ext;
   logic [AccW-1:0]          sum;
   logic                     last;
   logic                     accept;

   halut_lut_regfile #(
      .C             (C),
      .K             (K),
      .DataTypeWidth (DataTypeWidth)
   ) i_lut (
      .clk_i   (clk_i),
      .we_i    (lut_we_i),
      .wc_i    (lut_wc_i),
      .wk_i    (lut_wk_i),
      .wdata_i (lut_wdata_i),
      .rc_i    (c_q),
      .rk_i    (enc_k_i),
      .rdata_o (entry)
   );

   assign last      = (c_q == CLast);
   // Only the final index stalls, and only on an undrained result.
   assign enc_ready_o = !(last && vld_q && !result_ready_i);
   assign accept    = enc_valid_i && enc_ready_o;
   assign entry_ext = {{CW{entry[DataTypeWidth-1]}}, entry};
   assign sum       = ((c_q == '0) ? '0 : acc_q) + entry_ext;

   always_comb begin
      c_d    = c_q;
      acc_d  = acc_q;
      res_d  = res_q;
      vld_d  = vld_q;
      row_d  = row_q;
      rcnt_d = rcnt_q;
      if (vld_q && result_ready_i) begin
         vld_d = 1'b0;
      end
      if (accept) begin
         c_d   = last ? '0 : c_q + 1'b1;
         acc_d = sum;
         if (last) begin
            res_d  = sum;
            vld_d  = 1'b1;
            row_d  = rcnt_q;
            rcnt_d = rcnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         c_q    <= '0;
         acc_q  <= '0;
         res_q  <= '0;
         vld_q  <= 1'b0;
         row_q  <= '0;
         rcnt_q <= '0;
      end else begin
         c_q    <= c_d;
         acc_q  <= acc_d;
         res_q  <= res_d;
         vld_q  <= vld_d;
         row_q  <= row_d;
         rcnt_q <= rcnt_d;
      end
   end

   assign result_valid_o = vld_q;
   assign result_o       = res_q;
   assign row_o          = row_q;

endmodule

// File: tb/tb_halut_decoder_int.sv
// Directed + randomized bench for halut_decoder_int with a LUT/sum model.
module tb_halut_decoder_int;

   localparam int NC = 32;
   localparam int NK = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        lut_we_i;
   logic [4:0]  lut_wc_i;
   logic [3:0]  lut_wk_i;
   logic [15:0] lut_wdata_i;
   logic        enc_valid_i;
   logic        enc_ready_o;
   logic [3:0]  enc_k_i;
   logic        result_valid_o;
   logic        result_ready_i;
   logic [20:0] result_o;
   logic [15:0] row_o;

   int lut [NC][NK];
   int cur_k [NC];
   int exp_row;
   int passed;
   int total;
   int exp_a;
   int exp_b;

   halut_decoder_int dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .lut_we_i       (lut_we_i),
      .lut_wc_i       (lut_wc_i),
      .lut_wk_i       (lut_wk_i),
      .lut_wdata_i    (lut_wdata_i),
      .enc_valid_i    (enc_valid_i),
      .enc_ready_o    (enc_ready_o),
      .enc_k_i        (enc_k_i),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .result_o       (result_o),
      .row_o          (row_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int res_s();
      return int'($signed(result_o));
   endfunction

   function automatic int model_sum();
      int s = 0;
      for (int c = 0; c < NC; c++) s += lut[c][cur_k[c]];
      return s;
   endfunction

   task automatic wr(input int c, input int k, input int v);
      lut_we_i    = 1'b1;
      lut_wc_i    = 5'(c);
      lut_wk_i    = 4'(k);
      lut_wdata_i = 16'(v);
      tick();
      lut_we_i = 1'b0;
      lut[c][k] = v;
   endtask

   task automatic fill(input int v);
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < NK; k++) wr(c, k, v);
   endtask

   task automatic fill_rand();
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < NK; k++)
            wr(c, k, int'($urandom_range(0, 65535)) - 32768);
   endtask

   task automatic rand_k();
      for (int c = 0; c < NC; c++) cur_k[c] = int'($urandom_range(0, NK - 1));
   endtask

   // Streams one row (ready must let the final index through).
   task automatic send_row(input bit wr0, input int wval, input bit gaps);
      int e;
      e = model_sum();
      for (int c = 0; c < NC; c++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            enc_valid_i = 1'b0;
            enc_k_i     = 4'($urandom_range(0, NK - 1));
            tick();
         end
         enc_valid_i = 1'b1;
         enc_k_i     = 4'(cur_k[c]);
         if (c == 0 && wr0) begin
            lut_we_i    = 1'b1;
            lut_wc_i    = 5'd0;
            lut_wk_i    = 4'(cur_k[0]);
            lut_wdata_i = 16'(wval);
         end
         tick();
         lut_we_i = 1'b0;
         if (c == 0 && wr0) lut[0][cur_k[0]] = wval;
      end
      enc_valid_i = 1'b0;
      check("row_valid", int'(result_valid_o), 1);
      check("row_sum", res_s(), e);
      check("row_idx", int'(row_o), exp_row & 16'hFFFF);
      exp_row++;
   endtask

   initial begin
      passed = 0;
      total = 0;
      exp_row = 0;
      rst_ni = 1'b0;
      lut_we_i = 1'b0;
      lut_wc_i = '0;
      lut_wk_i = '0;
      lut_wdata_i = '0;
      enc_valid_i = 1'b0;
      enc_k_i = '0;
      result_ready_i = 1'b1;
      #3;
      check("rst_ready", int'(enc_ready_o), 1);
      check("rst_valid", int'(result_valid_o), 0);
      check("rst_result", res_s(), 0);
      check("rst_row", int'(row_o), 0);
      tick();
      tick();
      #2 rst_ni = 1'b1;
      tick();

      // Basic sum: LUT[c][3] = c+1
      fill(0);
      for (int c = 0; c < NC; c++) wr(c, 3, c + 1);
      for (int c = 0; c < NC; c++) cur_k[c] = 3;
      send_row(1'b0, 0, 1'b0);
      check("basic_528", res_s(), 528);

      // Width boundaries
      fill(-32768);
      rand_k();
      send_row(1'b0, 0, 1'b0);
      check("min_sum", res_s(), -1048576);
      fill(32767);
      rand_k();
      send_row(1'b0, 0, 1'b0);
      check("max_sum", res_s(), 1048544);

      // Random LUT, random rows, random input gaps
      fill_rand();
      for (int r = 0; r < 6; r++) begin
         rand_k();
         send_row(1'b0, 0, r[0]);
      end

      // Backpressure: two rows back to back with ready low
      tick();
      result_ready_i = 1'b0;
      rand_k();
      exp_a = model_sum();
      send_row(1'b0, 0, 1'b0);
      rand_k();
      exp_b = model_sum();
      for (int c = 0; c < NC - 1; c++) begin
         enc_valid_i = 1'b1;
         enc_k_i = 4'(cur_k[c]);
         #1;
         if (c == 0 || c == NC - 2) check("bp_ready_hi", int'(enc_ready_o), 1);
         tick();
         check("bp_hold", res_s(), exp_a);
      end
      enc_k_i = 4'(cur_k[NC - 1]);
      #1;
      check("bp_stall", int'(enc_ready_o), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_stall_hold", res_s(), exp_a);
         check("bp_stall_rdy", int'(enc_ready_o), 0);
         check("bp_stall_vld", int'(result_valid_o), 1);
      end
      result_ready_i = 1'b1;
      #1;
      check("bp_release", int'(enc_ready_o), 1);
      tick();
      enc_valid_i = 1'b0;
      check("bp_b_valid", int'(result_valid_o), 1);
      check("bp_b_sum", res_s(), exp_b);
      check("bp_b_row", int'(row_o), exp_row & 16'hFFFF);
      exp_row++;

      // Reset mid-row while a result is pending
      result_ready_i = 1'b0;
      rand_k();
      for (int c = 0; c < 10; c++) begin
         enc_valid_i = 1'b1;
         enc_k_i = 4'(cur_k[c]);
         tick();
      end
      enc_valid_i = 1'b0;
      check("pre_rst_valid", int'(result_valid_o), 1);
      #2 rst_ni = 1'b0;
      #1;
      check("mid_rst_valid", int'(result_valid_o), 0);
      check("mid_rst_result", res_s(), 0);
      check("mid_rst_row", int'(row_o), 0);
      check("mid_rst_ready", int'(enc_ready_o), 1);
      #5 rst_ni = 1'b1;
      tick();
      exp_row = 0;
      result_ready_i = 1'b1;
      rand_k();
      send_row(1'b0, 0, 1'b0);

      // Write/read collision on LUT[0][5]
      wr(0, 5, 7);
      rand_k();
      cur_k[0] = 5;
      send_row(1'b1, 100, 1'b0);
      rand_k();
      cur_k[0] = 5;
      send_row(1'b0, 0, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
